ram_seq_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the synchronous single-port RAM (8-bit address, 8-bit data, write-enable, one-cycle registered read, write-first).
- Executes one block command at a time over an address range: COPY (src to dst), FILL (constant to dst) or CHECKSUM (sum of src bytes).
- Drives the RAM's address, write-data and write-enable, and consumes its read-data output.
- Provides a start/busy/done handshake to the controlling testbench or CPU stage.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_seq_ctrl_if.sv | 34 +++
 rtl/range_chk.sv | 18 +
 rtl/ram_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM block sequencer: command opcodes, FSM states
// and the default RAM depth.
package ram_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 11;
  localparam int unsigned CSUM_W        = 16;

  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_FILL = 2'd1,
    OP_SUM  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StCopyRd,
    StCopyWr,
    StFill,
    StSumRd,
    StSumLast,
    StDone
  } state_e;

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Command/status handshake plus RAM-side bus of the block sequencer.
// The master side issues commands and models the RAM; the slave side is the sequencer.
interface ram_seq_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  import ram_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [AW-1:0]     src;
  logic [AW-1:0]     dst;
  logic [AW-1:0]     len;
  logic [DW-1:0]     fill_val;
  logic              busy;
  logic              done;
  logic              err;
  logic [CSUM_W-1:0] checksum;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we;
  logic [DW-1:0]     mem_rdata;

  modport master (
    output start, op, src, dst, len, fill_val, mem_rdata,
    input  busy, done, err, checksum, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  start, op, src, dst, len, fill_val, mem_rdata,
    output busy, done, err, checksum, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/range_chk.sv
// Combinational legality check of an address range: the end address is formed
// one bit wider than the address so that it can never wrap.
module range_chk #(
  parameter int unsigned AW = 8
) (
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] len,
  input  logic [AW:0]   depth,
  output logic          ok
);

  logic [AW:0] range_end;

  assign range_end = {1'b0, start_addr} + {1'b0, len};
  // An end equal to depth is the last legal word plus one, so it is accepted.
  assign ok        = (range_end <= depth);

endmodule

// File: rtl/ram_seq_ctrl.sv
// Block command sequencer in front of a single-port synchronous RAM: COPY, FILL and
// CHECKSUM over an address range with a start/busy/done handshake.
module ram_seq_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_seq_ctrl_if.slave  bus
);

  localparam logic [AW:0]   DepthW = (AW + 1)'(MEM_DEPTH);
  localparam logic [AW-1:0] One    = AW'(1);

  state_e              state_q, state_d;
  state_e              run_st;
  logic [AW-1:0]       src_q, src_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic [AW-1:0]       len_q, len_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       fill_q, fill_d;
  logic [CSUM_W-1:0]   sum_q, sum_d;
  logic [CSUM_W-1:0]   rdata_ext;
  logic                err_q, err_d;
  logic                src_ok, dst_ok, cmd_ok, last;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_we;

  range_chk #(
    .AW(AW)
  ) u_src_chk (
    .start_addr(bus.src),
    .len       (bus.len),
    .depth     (DepthW),
    .ok        (src_ok)
  );

  range_chk #(
    .AW(AW)
  ) u_dst_chk (
    .start_addr(bus.dst),
    .len       (bus.len),
    .depth     (DepthW),
    .ok        (dst_ok)
  );

  assign rdata_ext = CSUM_W'(bus.mem_rdata);
  assign last      = (idx_q == (len_q - One));

  // Only the ranges a command actually touches are checked.
  always_comb begin
    cmd_ok = 1'b0;
    run_st = StDone;
    unique case (op_e'(bus.op))
      OP_COPY: begin
        cmd_ok = src_ok & dst_ok;
        run_st = StCopyRd;
      end
      OP_FILL: begin
        cmd_ok = dst_ok;
        run_st = StFill;
      end
      OP_SUM: begin
        cmd_ok = src_ok;
        run_st = StSumRd;
      end
      default: begin
        cmd_ok = 1'b0;
        run_st = StDone;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fill_d    = fill_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    err_d     = err_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          src_d  = bus.src;
          dst_d  = bus.dst;
          len_d  = bus.len;
          fill_d = bus.fill_val;
          idx_d  = '0;
          sum_d  = '0;
          err_d  = 1'b0;
          if (!cmd_ok) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bus.len == '0) begin
            state_d = StDone;
          end else begin
            state_d = run_st;
          end
        end
      end

      StCopyRd: begin
        mem_addr = src_q + idx_q;
        state_d  = StCopyWr;
      end

      StCopyWr: begin
        mem_addr  = dst_q + idx_q;
        mem_wdata = bus.mem_rdata;
        mem_we    = 1'b1;
        sum_d     = sum_q + rdata_ext;
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + One;
          state_d = StCopyRd;
        end
      end

      StFill: begin
        mem_addr  = dst_q + idx_q;
        mem_wdata = fill_q;
        mem_we    = 1'b1;
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + One;
        end
      end

      // Reads are pipelined: the data on mem_rdata belongs to the previous issue.
      StSumRd: begin
        mem_addr = src_q + idx_q;
        if (idx_q != '0) begin
          sum_d = sum_q + rdata_ext;
        end
        if (last) begin
          state_d = StSumLast;
        end else begin
          idx_d = idx_q + One;
        end
      end

      StSumLast: begin
        sum_d   = sum_q + rdata_ext;
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q != StIdle) && (state_q != StDone);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;
  assign bus.checksum  = sum_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Self-checking bench for ram_seq_ctrl: a behavioural RAM, a word-level reference
// model of each command, directed scenarios and randomized commands.
module tb_ram_seq_ctrl;
  import ram_pkg::*;

  localparam int MemDepth = 11;

  logic clk = 1'b0;
  logic rst_n;

  ram_seq_ctrl_if #(.AW(8), .DW(8)) bus ();

  ram_seq_ctrl #(
    .MEM_DEPTH(MemDepth),
    .AW       (8),
    .DW       (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [0:255];
  logic [7:0] pre_img [0:255];
  logic [7:0] ref_mem [0:255];
  logic       pre_load;
  int         we_cnt  = 0;
  int         oob_cnt = 0;
  int         n_cmp   = 0;
  int         n_fail  = 0;

  // Write-first synchronous RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= pre_img[i];
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : ram[bus.mem_addr];
    if (bus.mem_we) begin
      we_cnt <= we_cnt + 1;
      if (int'(bus.mem_addr) >= MemDepth) oob_cnt <= oob_cnt + 1;
    end
  end

  task automatic load_image();
    pre_load = 1'b1;
    @(posedge clk);
    #1 pre_load = 1'b0;
  endtask

  task automatic preload_plan();
    int plan [0:10] = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 100, 101};
    for (int i = 0; i < 256; i++) begin
      pre_img[i] = (i < MemDepth) ? 8'(plan[i]) : 8'(i);
      ref_mem[i] = pre_img[i];
    end
    load_image();
  endtask

  task automatic preload_random();
    for (int i = 0; i < 256; i++) begin
      pre_img[i] = 8'($urandom_range(0, 255));
      ref_mem[i] = pre_img[i];
    end
    load_image();
  endtask

  // Reference model: applies a command word by word to ref_mem.
  task automatic model_cmd(input int op, input int src, input int dst, input int len,
                           input logic [7:0] fill, output bit e_err, output int e_sum,
                           output int e_lat, output int e_wr);
    bit bad;
    bad = (op == 3) ||
          ((op == 0 || op == 2) && (src + len > MemDepth)) ||
          ((op == 0 || op == 1) && (dst + len > MemDepth));
    e_err = bad;
    e_sum = 0;
    e_lat = 1;
    e_wr  = 0;
    if (!bad && len != 0) begin
      case (op)
        0: begin
          for (int k = 0; k < len; k++) begin
            ref_mem[dst + k] = ref_mem[src + k];
            e_sum += int'(ref_mem[dst + k]);
          end
          e_lat = 2 * len + 1;
          e_wr  = len;
        end
        1: begin
          for (int k = 0; k < len; k++) ref_mem[dst + k] = fill;
          e_lat = len + 1;
          e_wr  = len;
        end
        default: begin
          for (int k = 0; k < len; k++) e_sum += int'(ref_mem[src + k]);
          e_lat = len + 2;
        end
      endcase
    end
  endtask

  task automatic check_mem(input string name);
    int bad_cnt;
    int first_bad;
    bad_cnt   = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== ref_mem[i]) begin
        bad_cnt++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_cmp++;
    if (bad_cnt != 0) begin
      n_fail++;
      $display("FAIL %s ram: %0d words differ, addr %0d got %0d want %0d", name, bad_cnt,
               first_bad, ram[first_bad], ref_mem[first_bad]);
    end
  endtask

  // Issues one command, optionally poking start while busy and in DONE, and checks it.
  task automatic run_cmd(input string name, input int op, input int src, input int dst,
                         input int len, input logic [7:0] fill, input bit poke);
    bit   e_err;
    int   e_sum, e_lat, e_wr, cycles, we0, oob0;
    model_cmd(op, src, dst, len, fill, e_err, e_sum, e_lat, e_wr);
    @(negedge clk);
    bus.op       = 2'(op);
    bus.src      = 8'(src);
    bus.dst      = 8'(dst);
    bus.len      = 8'(len);
    bus.fill_val = fill;
    bus.start    = 1'b1;
    we0  = we_cnt;
    oob0 = oob_cnt;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.src      = 8'($urandom);
    bus.dst      = 8'($urandom);
    bus.len      = 8'($urandom);
    bus.fill_val = 8'($urandom);
    cycles = 1;
    n_cmp++;
    if (bus.busy !== (e_lat > 1)) begin
      n_fail++;
      $display("FAIL %s busy_after_accept: got %0b want %0b", name, bus.busy, e_lat > 1);
    end
    while (bus.done !== 1'b1 && cycles < 1000) begin
      if (poke && cycles == 2) begin
        bus.op = 2'd1; bus.dst = 8'd0; bus.len = 8'd1; bus.fill_val = 8'hEE;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (cycles != e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, cycles, e_lat);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.err !== e_err) begin
      n_fail++;
      $display("FAIL %s done_status: busy %0b err %0b want busy 0 err %0b", name, bus.busy,
               bus.err, e_err);
    end
    n_cmp++;
    if (bus.checksum !== 16'(e_sum)) begin
      n_fail++;
      $display("FAIL %s checksum: got %0d want %0d", name, bus.checksum, e_sum);
    end
    if (poke) begin
      bus.op = 2'd1; bus.dst = 8'd0; bus.len = 8'd1; bus.fill_val = 8'hEE;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== e_err) begin
      n_fail++;
      $display("FAIL %s after_done: done %0b busy %0b err %0b want 0 0 %0b", name, bus.done,
               bus.busy, bus.err, e_err);
    end
    n_cmp++;
    if (we_cnt - we0 != e_wr || oob_cnt != oob0) begin
      n_fail++;
      $display("FAIL %s writes: got %0d (oob %0d) want %0d (oob 0)", name, we_cnt - we0,
               oob_cnt - oob0, e_wr);
    end
    check_mem(name);
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.checksum !== 16'd0 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 8'd0 ||
        bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: busy %0b done %0b err %0b sum %0d addr %0d wdata %0d we %0b want all 0",
               name, bus.busy, bus.done, bus.err, bus.checksum, bus.mem_addr, bus.mem_wdata,
               bus.mem_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_copy();
    preload_plan();
    run_cmd("copy_0_5_3", 0, 0, 5, 3, 8'h00, 1'b0);
  endtask

  task automatic test_fill();
    run_cmd("fill_8_3", 1, 0, 8, 3, 8'hAA, 1'b0);
  endtask

  task automatic test_checksum();
    preload_plan();
    run_cmd("sum_0_11", 2, 0, 0, 11, 8'h00, 1'b0);
  endtask

  task automatic test_errors();
    preload_plan();
    run_cmd("copy_range_err", 0, 9, 0, 3, 8'h00, 1'b0);
    run_cmd("op_reserved", 3, 0, 0, 2, 8'h00, 1'b0);
    run_cmd("len_zero", 0, 0, 5, 0, 8'h00, 1'b0);
    run_cmd("fill_end_eq_depth", 1, 0, 8, 3, 8'h3C, 1'b0);
    run_cmd("fill_end_over", 1, 0, 9, 3, 8'h3C, 1'b0);
  endtask

  task automatic test_overlap();
    preload_plan();
    run_cmd("copy_overlap", 0, 0, 1, 3, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    preload_plan();
    @(negedge clk);
    bus.op = 2'd1; bus.dst = 8'd0; bus.len = 8'd10; bus.fill_val = 8'h5C;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset_mid_fill");
    for (int k = 0; k < 4; k++) ref_mem[k] = 8'h5C;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_mem("reset_mid_fill");
    run_cmd("sum_after_reset", 2, 0, 0, 11, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    preload_plan();
    run_cmd("copy_poked", 0, 2, 6, 4, 8'h00, 1'b1);
    run_cmd("sum_poked", 2, 1, 0, 7, 8'h00, 1'b1);
    run_cmd("fill_poked", 1, 0, 3, 5, 8'h77, 1'b1);
  endtask

  task automatic test_random();
    preload_random();
    for (int n = 0; n < 40; n++) begin
      run_cmd("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    pre_load     = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'd0;
    bus.src      = 8'd0;
    bus.dst      = 8'd0;
    bus.len      = 8'd0;
    bus.fill_val = 8'd0;
    test_reset();
    test_copy();
    test_fill();
    test_checksum();
    test_errors();
    test_overlap();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
